// File: rtl/alu_issue_seq_if.sv
// Request, ALU-drive and result channels of alu_issue_seq, bundled as one interface.
// master = the surrounding system (requester, ALU, consumer); slave = alu_issue_seq.
interface alu_issue_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_cmd;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        alu_zero;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carryout;
  logic        out_overflow;
  logic        out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready,
           alu_result, alu_carryout, alu_overflow, alu_zero,
    input  in_ready, alu_a, alu_b, alu_sel,
           out_valid, out_result, out_carryout, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready,
           alu_result, alu_carryout, alu_overflow, alu_zero,
    output in_ready, alu_a, alu_b, alu_sel,
           out_valid, out_result, out_carryout, out_overflow, out_zero
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issues one request to an external combinational ALU, holds operands SETTLE_CYCLES edges,
// then captures its outputs. Optional macro ALU_ISSUE_SLT_EN: reduce SLT to a 0/1 result.
module alu_issue_seq #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_seq_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_r, state_s;
  logic [3:0]  cnt_r;
  logic        in_ready_s, accept_s, capture_s, busy_s;
  logic [31:0] alu_a_r, alu_b_r;
  logic [2:0]  alu_sel_r;
  logic [31:0] out_result_r, cap_result_s;
  logic        out_carryout_r, out_overflow_r, out_zero_r, out_valid_r;
  logic        cap_carryout_s, cap_overflow_s, cap_zero_s;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = SETTLE; else state_s = IDLE;
      SETTLE:  if (cnt_r == 4'd0) state_s = DONE; else state_s = SETTLE;
      DONE: begin
        if (bus.out_ready) state_s = accept_s ? SETTLE : IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // per-state handshake and capture decodes
  always_comb begin
    in_ready_s = 1'b0;
    capture_s  = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      IDLE:   in_ready_s = 1'b1;
      SETTLE: begin
        busy_s    = 1'b1;
        capture_s = (cnt_r == 4'd0);
      end
      DONE: begin
        busy_s     = 1'b1;
        in_ready_s = bus.out_ready;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       cnt_r <= 4'd0;
    else if (accept_s)                                cnt_r <= CNT_LOAD;
    else if ((state_r == SETTLE) && (cnt_r != 4'd0))  cnt_r <= cnt_r - 4'd1;
    else                                              cnt_r <= cnt_r;
  end

  // operands driven to the ALU, stable until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      alu_sel_r <= 3'd0;
    end else if (accept_s) begin
      alu_a_r   <= bus.in_a;
      alu_b_r   <= bus.in_b;
      alu_sel_r <= bus.in_cmd;
    end
  end

  // value presented to the capture registers
  always_comb begin
    cap_result_s   = bus.alu_result;
    cap_carryout_s = bus.alu_carryout;
    cap_overflow_s = bus.alu_overflow;
    cap_zero_s     = bus.alu_zero;
`ifdef ALU_ISSUE_SLT_EN
    // SLT: the ALU supplies a-b; signed less-than is sign XOR overflow
    if (alu_sel_r == 3'd3) begin
      cap_result_s   = {31'd0, bus.alu_result[31] ^ bus.alu_overflow};
      cap_carryout_s = 1'b0;
      cap_overflow_s = 1'b0;
      cap_zero_s     = ~(bus.alu_result[31] ^ bus.alu_overflow);
    end else begin
      cap_zero_s     = bus.alu_zero;
    end
`endif
  end

  // result capture and out_valid handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_r   <= 32'd0;
      out_carryout_r <= 1'b0;
      out_overflow_r <= 1'b0;
      out_zero_r     <= 1'b0;
      out_valid_r    <= 1'b0;
    end else if (capture_s) begin
      out_result_r   <= cap_result_s;
      out_carryout_r <= cap_carryout_s;
      out_overflow_r <= cap_overflow_s;
      out_zero_r     <= cap_zero_s;
      out_valid_r    <= 1'b1;
    end else if ((state_r == DONE) && bus.out_ready) begin
      out_valid_r    <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_s & rst_n;
  assign bus.alu_a        = alu_a_r;
  assign bus.alu_b        = alu_b_r;
  assign bus.alu_sel      = alu_sel_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_result   = out_result_r;
  assign bus.out_carryout = out_carryout_r;
  assign bus.out_overflow = out_overflow_r;
  assign bus.out_zero     = out_zero_r;
  assign busy             = busy_s;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed handshake sequences, a constant vector
// table and randomized transactions against a transaction-level reference model.
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_seq_if bus0 ();
  alu_issue_seq_if bus1 ();

  alu_issue_seq #(.SETTLE_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  alu_issue_seq #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  // Behavioural ALU: {result, carry, overflow, zero}; SUB/SLT compute a-b.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] cmd);
    logic [32:0] s;
    logic [31:0] r;
    logic c, o;
    s = 33'd0; r = 32'd0; c = 1'b0; o = 1'b0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, c, o, (r == 32'd0)};
  endfunction

  // Expected captured outputs for a request.
  function automatic logic [34:0] exp_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] cmd);
    logic [34:0] v;
    v = alu_fn(a, b, cmd);
`ifdef ALU_ISSUE_SLT_EN
    if (cmd == 3'd3) begin
      v = {31'd0, ($signed(a) < $signed(b)), 1'b0, 1'b0, !($signed(a) < $signed(b))};
    end
`endif
    return v;
  endfunction

  logic [34:0] alu0_s, alu1_s;
  assign alu0_s = alu_fn(bus0.alu_a, bus0.alu_b, bus0.alu_sel);
  assign alu1_s = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
  assign bus0.alu_result   = alu0_s[34:3];
  assign bus0.alu_carryout = alu0_s[2];
  assign bus0.alu_overflow = alu0_s[1];
  assign bus0.alu_zero     = alu0_s[0];
  assign bus1.alu_result   = alu1_s[34:3];
  assign bus1.alu_carryout = alu1_s[2];
  assign bus1.alu_overflow = alu1_s[1];
  assign bus1.alu_zero     = alu1_s[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] out0();
    return {bus0.out_result, bus0.out_carryout, bus0.out_overflow, bus0.out_zero};
  endfunction

  // Wait for out_valid after an accept edge; returns edges elapsed since accept.
  task automatic wait_out0(input int already, output int lat);
    lat = already;
    while (!bus0.out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic release0();
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
  endtask

  // Full transaction on dut0 with `hold` cycles of back-pressure after out_valid.
  task automatic txn0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                      input int hold, output logic [34:0] got, output int lat);
    int w;
    bus0.in_a = a; bus0.in_b = b; bus0.in_cmd = cmd; bus0.in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!bus0.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.in_a = $urandom; bus0.in_b = $urandom; bus0.in_cmd = 3'($urandom_range(0, 7));
    @(negedge clk);
    wait_out0(0, lat);
    repeat (hold) @(negedge clk);
    got = out0();
    release0();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cmd;
    logic [34:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [34:0] got, ex, snap;
  int          lat, bad_busy, bad_hold;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd2,          32'd3,          3'd0, {32'd5,          1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          3'd0, {32'd0,          1'b1, 1'b0, 1'b1}};
    vecs[2] = '{32'h7FFFFFFF,   32'd1,          3'd0, {32'h80000000,   1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'd5,          32'd7,          3'd1, {32'hFFFFFFFE,   1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'hF0F0F0F0,   32'hFFFFFFFF,   3'd2, {32'h0F0F0F0F,   1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'hF0F000FF,   32'h0FF00F0F,   3'd4, {32'h00F0000F,   1'b0, 1'b0, 1'b0}};
    vecs[6] = '{32'hF0F000FF,   32'h0FF00F0F,   3'd5, {32'hFF0FFFF0,   1'b0, 1'b0, 1'b0}};
    vecs[7] = '{32'h000000FF,   32'h0F000000,   3'd6, {32'hF0FFFF00,   1'b0, 1'b0, 1'b0}};
    vecs[8] = '{32'h000000FF,   32'h0F000000,   3'd7, {32'h0F0000FF,   1'b0, 1'b0, 1'b0}};
`ifdef ALU_ISSUE_SLT_EN
    vecs[9] = '{32'hFFFFFFFF,   32'd1,          3'd3, {32'd1,          1'b0, 1'b0, 1'b0}};
`else
    vecs[9] = '{32'hFFFFFFFF,   32'd1,          3'd3, {32'hFFFFFFFE,   1'b1, 1'b0, 1'b0}};
`endif

    bus0.in_valid = 1'b1; bus0.in_a = 32'd9; bus0.in_b = 32'd9; bus0.in_cmd = 3'd7;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = 32'd0; bus1.in_b = 32'd0; bus1.in_cmd = 3'd0;
    bus1.out_ready = 1'b0;

    // reset state, with in_valid asserted to show it is not accepted
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus0.in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
    chk("rst_alu_ops", {bus0.alu_a, bus0.alu_b}, 64'd0);
    chk("rst_outs", {29'd0, out0()}, 64'd0);

    // ADD 2+3: accept on the first edge after release, latency 4, busy throughout
    bus0.out_ready = 1'b0;
    bus0.in_a = 32'd2; bus0.in_b = 32'd3; bus0.in_cmd = 3'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0; bus0.in_a = 32'd77; bus0.in_b = 32'd88;
    bad_busy = 0;
    lat = 0;
    @(negedge clk);
    while (!bus0.out_valid && lat < 40) begin
      if (!busy0) bad_busy++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("add_latency", 64'(lat), 64'd4);
    chk("add_result", {29'd0, out0()}, {29'd0, 32'd5, 1'b0, 1'b0, 1'b0});
    chk("add_busy", 64'(bad_busy), 64'd0);
    chk("add_ops_held", {bus0.alu_a, bus0.alu_b}, {32'd2, 32'd3});

    // back-pressure for 10 cycles with a stray in_valid pulse
    snap = out0();
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus0.in_valid = 1'b1; bus0.in_a = 32'd99; end
      if (i == 4) bus0.in_valid = 1'b0;
      @(negedge clk);
      if (out0() !== snap || bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) bad_hold++;
    end
    chk("hold_stable", 64'(bad_hold), 64'd0);
    chk("hold_no_accept", {32'd0, bus0.alu_a}, 64'd2);

    // back-to-back SUB 7-7 handed off on the DONE edge
    @(posedge clk); #1;
    bus0.out_ready = 1'b1; bus0.in_valid = 1'b1;
    bus0.in_a = 32'd7; bus0.in_b = 32'd7; bus0.in_cmd = 3'd1;
    @(negedge clk);
    chk("b2b_in_ready", {63'd0, bus0.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus0.out_ready = 1'b0; bus0.in_valid = 1'b0; bus0.in_cmd = 3'd6;
    @(negedge clk);
    chk("b2b_handoff", {61'd0, bus0.out_valid, busy0, 1'b0}, {61'd0, 1'b0, 1'b1, 1'b0});
    chk("b2b_alu_sel", {61'd0, bus0.alu_sel}, 64'd1);
    wait_out0(0, lat);
    chk("b2b_latency", 64'(lat), 64'd4);
    chk("b2b_result", {29'd0, out0()}, {29'd0, 32'd0, 1'b1, 1'b0, 1'b1});
    release0();

    // constant vector table
    for (int i = 0; i < 10; i++) begin
      txn0(vecs[i].a, vecs[i].b, vecs[i].cmd, i % 3, got, lat);
      chk($sformatf("vec%0d_result", i), {29'd0, got}, {29'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rc;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      rc = 3'($urandom_range(0, 7));
      ex = exp_fn(ra, rb, rc);
      txn0(ra, rb, rc, $urandom_range(0, 3), got, lat);
      chk($sformatf("rnd%0d_result", i), {29'd0, got}, {29'd0, ex});
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd4);
    end

    // reset two cycles into SETTLE discards the request
    bus0.in_a = 32'hDEAD0001; bus0.in_b = 32'h1; bus0.in_cmd = 3'd0; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ops", {bus0.alu_a, bus0.alu_b}, 64'd0);
    chk("mid_rst_flags", {60'd0, bus0.out_valid, busy0, bus0.in_ready, (bus0.alu_sel != 3'd0)}, 64'd0);
    chk("mid_rst_outs", {29'd0, out0()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.in_a = 32'd10; bus0.in_b = 32'd20; bus0.in_cmd = 3'd0; bus0.in_valid = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, bus0.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    chk("post_rst_accept", {31'd0, busy0, bus0.alu_a}, {31'd0, 1'b1, 32'd10});
    @(negedge clk);
    wait_out0(0, lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_result", {29'd0, out0()}, {29'd0, 32'd30, 1'b0, 1'b0, 1'b0});
    release0();

    // SETTLE_CYCLES=1: capture on the edge after accept
    bus1.in_a = 32'hF0F0F0F0; bus1.in_b = 32'hFFFFFFFF; bus1.in_cmd = 3'd2; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus1.in_a = 32'd0;
    @(negedge clk);
    chk("s1_not_yet", {62'd0, bus1.out_valid, busy1}, 64'd1);
    @(negedge clk);
    chk("s1_out_valid", {63'd0, bus1.out_valid}, 64'd1);
    chk("s1_result", {32'd0, bus1.out_result}, 64'h0F0F0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter SETTLE_CYCLES, default 4, SHALL set the cycles operands are held on the ALU before its outputs are sampled; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_a, in_b  input  32 each  operands.
REQ-008 in_cmd  input  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-009 alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-010 alu_sel  output  3  registered command driven to the ALU selector.
REQ-011 alu_result  input  32; alu_carryout, alu_overflow, alu_zero  input  1 each  ALU outputs.
REQ-012 out_valid  output  1  captured result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_result  output  32; out_carryout, out_overflow, out_zero  output  1 each  captured ALU outputs.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETTLE, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise; it SHALL be 0 while rst_n=0.
REQ-018 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1. On that edge, alu_a, alu_b and alu_sel load in_a, in_b and in_cmd; the settle counter loads SETTLE_CYCLES-1; the state becomes SETTLE.
REQ-019 alu_a, alu_b and alu_sel SHALL hold their value until the next accept; inputs may change after the accept edge.
REQ-020 In SETTLE with counter>0, the counter SHALL decrement on each edge.
REQ-021 In SETTLE with counter=0, the next edge SHALL load the ALU outputs into the out_* registers, set out_valid=1 and enter DONE.
REQ-022 Latency: for an accept at edge E, out_valid SHALL rise at edge E+SETTLE_CYCLES.
REQ-023 In DONE, out_* and out_valid SHALL hold while out_ready=0.
REQ-024 In DONE with out_ready=1 and in_valid=0, the edge SHALL clear out_valid and enter IDLE.
REQ-025 In DONE with out_ready=1 and in_valid=1, the edge SHALL clear out_valid, accept the new request per REQ-018 and enter SETTLE (back-to-back; no IDLE bubble).
REQ-026 out_result, out_carryout and out_overflow SHALL retain their last captured values when out_valid is 0.
REQ-027 in_valid=1 while in_ready=0 SHALL be ignored; the block has no buffering beyond one request.
REQ-028 When SETTLE_CYCLES=1, the counter SHALL load 0 and capture SHALL occur on the edge after accept.

Reset
REQ-029 While rst_n=0, the block SHALL be in state IDLE with counter 0, alu_a=alu_b=0, alu_sel=0, out_result=0, out_carryout=out_overflow=out_zero=0, out_valid=0, busy=0.
REQ-030 Assertion of rst_n in SETTLE or DONE SHALL discard the in-flight request immediately, with no output handshake.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro ALU_ISSUE_SLT_EN SHALL be the sole compile-time option.
REQ-033 With ALU_ISSUE_SLT_EN defined and captured alu_sel=3 (SLT), out_result SHALL capture {31'b0, alu_result[31] XOR alu_overflow}, out_zero SHALL capture (that value==0), and out_carryout=out_overflow SHALL capture 0.
REQ-034 Without ALU_ISSUE_SLT_EN, all commands, including SLT, SHALL capture alu_result and the ALU flags unmodified.

Verification
REQ-035 Reset then ADD a=2, b=3, SETTLE_CYCLES=4, ALU model returns 5 -> out_valid rises 4 edges after accept, out_result=5, out_zero=0, busy=1 throughout.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid -> out_result stable, in_ready=0, and an in_valid pulse in this window is not accepted.
REQ-037 In DONE with out_ready=1 and in_valid=1 (SUB a=7, b=7) -> same-edge handoff, alu_sel=1, next out_result=0, out_zero=1, no IDLE cycle.
REQ-038 With ALU_ISSUE_SLT_EN: SLT a=-1, b=1, ALU returns 0xFFFFFFFE, overflow=0 -> out_result=1, out_zero=0; rebuilt without the macro -> out_result=0xFFFFFFFE.
REQ-039 Assert rst_n=0 two cycles into SETTLE -> all outputs are at their reset values immediately, out_valid never pulses, and in_ready=1 on the first edge after release.
REQ-040 SETTLE_CYCLES=1, XOR a=0xF0F0F0F0, b=0xFFFFFFFF -> out_valid on the edge after accept, out_result=0x0F0F0F0F.
